// File: rtl/g2b_rr_scheduler.sv
// Round-robin shared gray-to-binary converter: NREQ requesters, one registered result slot.
// Latency 1 cycle from accept to out_valid; no grants while the slot is full and out_ready=0.
module g2b_rr_scheduler #(
  parameter  int WIDTH = 4,
  parameter  int NREQ  = 4,
  parameter  int CNTW  = 16,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_gray,
  output logic [NREQ-1:0]         req_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_binary,
  output logic [IDW-1:0]          out_id,
  input  logic                    out_ready,
  output logic [CNTW-1:0]         conv_count,
  output logic                    busy
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  out_binary_q;
  logic [IDW-1:0]    out_id_q;
  logic [IDW-1:0]    last_grant_q;
  logic [CNTW-1:0]   conv_count_q;

  logic              slot_free;
  logic              grant_found;
  logic [IDW-1:0]    grant_idx;
  logic [IDW-1:0]    cand;
  logic [WIDTH-1:0]  sel_gray;
  logic              accept;
  logic              drain;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int k = WIDTH - 2; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

  // Search starts one past the last winner so the previous winner has lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_grant_q) + k) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_gray = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) sel_gray = req_gray[i*WIDTH +: WIDTH];
    end
  end

  assign drain     = out_valid && out_ready;
  assign slot_free = (state_q == EMPTY) || drain;

  always_comb begin
    req_ready = '0;
    if (rst_n && grant_found && slot_free) req_ready[grant_idx] = 1'b1;
  end

  assign accept = |(req_valid & req_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (accept) state_d = FULL;
               else if (out_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_q == FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_binary_q <= '0;
      out_id_q     <= '0;
      last_grant_q <= IDW'(NREQ - 1);
      conv_count_q <= '0;
    end else begin
      if (accept) begin
        out_binary_q <= gray2bin(sel_gray);
        out_id_q     <= grant_idx;
        last_grant_q <= grant_idx;
      end
      if (drain) conv_count_q <= conv_count_q + CNTW'(1);
    end
  end

  assign out_binary = out_binary_q;
  assign out_id     = out_id_q;
  assign conv_count = conv_count_q;
  assign busy       = out_valid || (|req_valid);

endmodule
